// File: rtl/act_pingpong_ctrl.sv
// act_pingpong_ctrl: ping-pong scheduler steering producer writes into two activation banks and handing full banks to MAC and plasticity consumers in fill order
//  in : clk, rst_n, abort, prod_start, prod_tag, prod_we, prod_waddr, prod_wdata, bank_valid[1:0], mac_done, plast_done
//  out: prod_ready, bank_we[1:0], bank_waddr, bank_wdata, bank_clear[1:0], cons_valid, cons_bank, cons_tag, err
module act_pingpong_ctrl #(
  parameter int NUM_NEURONS = 256,
  parameter int DATA_WIDTH  = 32,
  localparam int AW = $clog2(NUM_NEURONS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  abort,
  input  logic                  prod_start,
  input  logic                  prod_tag,
  output logic                  prod_ready,
  input  logic                  prod_we,
  input  logic [AW-1:0]         prod_waddr,
  input  logic [DATA_WIDTH-1:0] prod_wdata,
  output logic [1:0]            bank_we,
  output logic [AW-1:0]         bank_waddr,
  output logic [DATA_WIDTH-1:0] bank_wdata,
  output logic [1:0]            bank_clear,
  input  logic [1:0]            bank_valid,
  output logic                  cons_valid,
  output logic                  cons_bank,
  output logic                  cons_tag,
  input  logic                  mac_done,
  input  logic                  plast_done,
  output logic                  err
);
  typedef enum logic [1:0] {FREE, FILLING, FULL} bank_state_t;
  bank_state_t state [2];
  logic wr_ptr, rd_ptr, mac_f, plast_f;
  logic [1:0] tag;
  logic accept, release_bank, viol;
  assign bank_waddr = prod_waddr;
  assign bank_wdata = prod_wdata;
  always_comb begin
    prod_ready = (state[wr_ptr] == FREE) && (state[0] != FILLING) && (state[1] != FILLING);
    accept = prod_start & prod_ready & ~abort;
    bank_clear = accept ? (wr_ptr ? 2'b10 : 2'b01) : 2'b00;
    bank_we = '0;
    for (int i = 0; i < 2; i++) bank_we[i] = prod_we & ~abort & (state[i] == FILLING) & ~bank_clear[i];
    cons_valid = state[rd_ptr] == FULL;
    cons_bank = rd_ptr;
    cons_tag = tag[rd_ptr];
    // a same-cycle done counts together with the other consumer's sticky flag
    release_bank = cons_valid & (mac_f | mac_done) & (plast_f | plast_done);
    viol = (prod_start & ~prod_ready) | (prod_we & ~|bank_we) | ((mac_done | plast_done) & ~cons_valid);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state[0] <= FREE;
      state[1] <= FREE;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      tag <= '0;
      mac_f <= 1'b0;
      plast_f <= 1'b0;
      err <= 1'b0;
    end else if (abort) begin
      state[0] <= FREE;
      state[1] <= FREE;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      tag <= '0;
      mac_f <= 1'b0;
      plast_f <= 1'b0;
      err <= 1'b0;
    end else begin
      err <= viol;
      if (accept) begin
        state[wr_ptr] <= FILLING;
        tag[wr_ptr] <= prod_tag;
      end
      // only the wr_ptr bank can ever be FILLING, so completion is checked there alone
      if (state[wr_ptr] == FILLING && bank_valid[wr_ptr]) begin
        state[wr_ptr] <= FULL;
        wr_ptr <= ~wr_ptr;
      end
      if (release_bank) begin
        state[rd_ptr] <= FREE;
        rd_ptr <= ~rd_ptr;
        mac_f <= 1'b0;
        plast_f <= 1'b0;
      end else if (cons_valid) begin
        mac_f <= mac_f | mac_done;
        plast_f <= plast_f | plast_done;
      end
    end
  end
endmodule
